fwd_operand_stage: RTL and testbench
====================================

Name: fwd_operand_stage

Overview:
- Parametrised N-source operand-forwarding selector with a registered output stage.
- Used in the EX stage to select among register-file, EX/MEM and MEM/WB results. Replaces a purely combinational 3-to-1 select.
- Adds:
  - a valid/ready handshake;
  - source-readiness stalling on pending loads;
  - flush;
  - defined behaviour for out-of-range selects;
  - a stall-cycle counter for performance monitoring.

Parameters:
- DATA_W, 32, width of each source and of data_o.
- NUM_SRC, 3, number of sources, 2..16. Need not be a power of two.
- SEL_W, 2, width of sel_i. Must satisfy 2^SEL_W >= NUM_SRC.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk_i  in  1  clock. All state changes on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- src_data_i  in  NUM_SRC*DATA_W  source k occupies bits [k*DATA_W +: DATA_W].
- src_valid_i  in  NUM_SRC  source k holds a usable value.
- sel_i  in  SEL_W  source index.
- in_valid_i  in  1  upstream has an operand request.
- in_ready_o  out  1  the request is accepted this cycle.
- flush_i  in  1  kill the held and incoming operand.
- out_valid_o  out  1  data_o is valid.
- out_ready_i  in  1  downstream consumes data_o.
- data_o  out  DATA_W  registered selected operand.
- sel_err_o  out  1  sticky: an out-of-range select was accepted.
- stall_cnt_o  out  CNT_W  cycles spent stalled on a non-ready source.

Behaviour:
- Reset (async, rst_n_i=0): out_valid_o=0, data_o=0, sel_err_o=0, stall_cnt_o=0. Takes effect immediately, mid-transfer included; any pending transfer is lost.
- sel_ok = (sel_i < NUM_SRC).
- src_ok = !sel_ok || src_valid_i[sel_i]. An out-of-range select never waits.
- space = !out_valid_o || out_ready_i.
- in_ready_o = space && src_ok && !flush_i. Purely combinational; it must not depend on in_valid_i.
- accept = in_valid_i && in_ready_o.
- On accept:
  - out_valid_o <= 1 next edge.
  - data_o <= src_data_i[sel_i] if sel_ok, else 0.
  - If !sel_ok, sel_err_o <= 1. It stays 1 until reset.
- Consume (out_valid_o && out_ready_i) without accept: out_valid_o <= 0. data_o keeps its last value.
- Consume and accept in the same cycle: back-to-back transfer; out_valid_o stays 1 and data_o is updated. Throughput is 1 per cycle.
- Hold: out_valid_o && !out_ready_i leaves data_o and out_valid_o unchanged.
- Latency: request accepted at edge N, data_o valid after edge N.
- Stall: in_valid_i && space && !src_ok && !flush_i increments stall_cnt_o. It saturates at 2^CNT_W-1 and never wraps. Back-pressure cycles (!space) are not counted.
- Flush, highest priority:
  - out_valid_o <= 0 next edge.
  - No accept that cycle; in_ready_o=0.
  - data_o unchanged.
  - sel_err_o and stall_cnt_o unchanged.
  - No stall count that cycle.
- src_valid_i, src_data_i and sel_i are sampled only at accept. Later changes do not affect the held data_o.
- Simultaneous flush_i and out_ready_i: out_valid_o <= 0. The consume is counted as done downstream.

Test Plan:
1. Basic select, NUM_SRC=3: all valid; src = 0x11111111 / 0x22222222 / 0x33333333; sel_i = 0,1,2 on consecutive cycles; out_ready_i=1 -> data_o = 0x11111111, 0x22222222, 0x33333333 one cycle later each; out_valid_o continuously 1; in_ready_o=1 throughout.
2. Load-use stall: sel_i=1, src_valid_i[1]=0 for 3 cycles then 1 -> in_ready_o=0 for 3 cycles; stall_cnt_o=3; accept on the 4th cycle with data_o = src1 value.
3. Back-pressure: out_valid_o=1 with data 0xDEADBEEF; out_ready_i=0 for 4 cycles while new requests arrive -> data_o holds 0xDEADBEEF; in_ready_o=0; stall_cnt_o unchanged; on release, the next operand is accepted in the same cycle.
4. Out-of-range select: NUM_SRC=3, sel_i=3 with in_valid_i=1 -> accepted; data_o=0; sel_err_o=1 and stays 1 after further valid transfers until rst_n_i pulses low.
5. Flush: hold 0xCAFEF00D with out_ready_i=0; assert flush_i together with a valid request -> next cycle out_valid_o=0; request not accepted (in_ready_o=0 that cycle); data_o still 0xCAFEF00D.
6. Async reset mid-stream plus saturation: CNT_W=4, stall for 20 cycles -> stall_cnt_o=15. Then drop rst_n_i between clock edges -> all outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fwd_operand_stage_if.sv
// Operand-forwarding stage bus: source data/valid, select, and the in/out handshakes.
// The master modport is the driving side; the slave modport belongs to fwd_operand_stage.
interface fwd_operand_stage_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned CNT_W   = 16
);
    logic [NUM_SRC*DATA_W-1:0] src_data_i;
    logic [NUM_SRC-1:0]        src_valid_i;
    logic [SEL_W-1:0]          sel_i;
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic                      flush_i;
    logic                      out_valid_o;
    logic                      out_ready_i;
    logic [DATA_W-1:0]         data_o;
    logic                      sel_err_o;
    logic [CNT_W-1:0]          stall_cnt_o;

    modport master (
        output src_data_i, src_valid_i, sel_i, in_valid_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_o, sel_err_o, stall_cnt_o
    );

    modport slave (
        input  src_data_i, src_valid_i, sel_i, in_valid_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, data_o, sel_err_o, stall_cnt_o
    );
endinterface

// File: rtl/fwd_operand_stage.sv
// EX-stage operand forwarding: N-way source select into a registered valid/ready output,
// with load-use stalling, flush, sticky out-of-range select error and a saturating stall counter.
module fwd_operand_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned CNT_W   = 16
) (
    input logic                clk_i,
    input logic                rst_n_i,
    fwd_operand_stage_if.slave bus
);

    logic              sel_ok;
    logic              src_ok;
    logic              space;
    logic              accept;
    logic              stall;
    logic [DATA_W-1:0] sel_data;

    logic              out_valid_q;
    logic [DATA_W-1:0] data_q;
    logic              sel_err_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    // Loop-compare select avoids indexing past NUM_SRC; unmatched selects yield zero and never wait.
    always_comb begin
        sel_ok   = 1'b0;
        src_ok   = 1'b1;
        sel_data = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (32'(bus.sel_i) == k) begin
                sel_ok   = 1'b1;
                src_ok   = bus.src_valid_i[k];
                sel_data = bus.src_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign space          = !out_valid_q || bus.out_ready_i;
    assign bus.in_ready_o = space && src_ok && !bus.flush_i;
    assign accept         = bus.in_valid_i && bus.in_ready_o;
    assign stall          = bus.in_valid_i && space && !src_ok && !bus.flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            sel_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (bus.flush_i) begin
                out_valid_q <= 1'b0;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                data_q      <= sel_data;
                if (!sel_ok) begin
                    sel_err_q <= 1'b1;
                end
            end else if (out_valid_q && bus.out_ready_i) begin
                out_valid_q <= 1'b0;
            end

            if (stall && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.out_valid_o = out_valid_q;
    assign bus.data_o      = data_q;
    assign bus.sel_err_o   = sel_err_q;
    assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Bench for fwd_operand_stage (NUM_SRC=3, CNT_W=4): directed scenarios plus random traffic,
// all checked cycle by cycle against a behavioural model of the operand slot.
module tb_fwd_operand_stage;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NUM_SRC = 3;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CNT_W   = 4;

    logic clk;
    logic rst_n;

    fwd_operand_stage_if #(
        .DATA_W (DATA_W),
        .NUM_SRC(NUM_SRC),
        .SEL_W  (SEL_W),
        .CNT_W  (CNT_W)
    ) bus ();

    fwd_operand_stage #(
        .DATA_W (DATA_W),
        .NUM_SRC(NUM_SRC),
        .SEL_W  (SEL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks;
    int n_pass;

    // Stimulus state
    logic [31:0] src [3];
    logic [2:0]  sv;
    int          sel;
    logic        iv;
    logic        fl;
    logic        ordy;

    // Model of the single output slot
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_err;
    int          m_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic apply();
        bus.src_data_i  = {src[2], src[1], src[0]};
        bus.src_valid_i = sv;
        bus.sel_i       = SEL_W'(sel);
        bus.in_valid_i  = iv;
        bus.flush_i     = fl;
        bus.out_ready_i = ordy;
    endtask

    task automatic drive(input logic v, input int s, input logic [2:0] valids,
                         input logic f, input logic r);
        iv = v; sel = s; sv = valids; fl = f; ordy = r;
        apply();
    endtask

    // One clock: check in_ready ahead of the edge, advance the model, check registered outputs after.
    task automatic step();
        bit src_ready, has_room, exp_rdy, take;
        #3;
        src_ready = (sel >= 3) || sv[sel];
        has_room  = !m_valid || ordy;
        exp_rdy   = has_room && src_ready && !fl;
        take      = iv && exp_rdy;
        chk("in_ready", 64'(bus.in_ready_o), 64'(exp_rdy));
        if (iv && has_room && !src_ready && !fl && m_cnt < 15)
            m_cnt++;
        if (fl) begin
            m_valid = 1'b0;
        end else if (take) begin
            m_valid = 1'b1;
            m_data  = (sel < 3) ? src[sel] : 32'h0;
            if (sel >= 3) m_err = 1'b1;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 64'(bus.out_valid_o), 64'(m_valid));
        chk("data",      64'(bus.data_o),      64'(m_data));
        chk("sel_err",   64'(bus.sel_err_o),   64'(m_err));
        chk("stall_cnt", 64'(bus.stall_cnt_o), 64'(m_cnt));
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_err   = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 64'(bus.out_valid_o), 64'h0);
        chk({tag, "_data"},  64'(bus.data_o),      64'h0);
        chk({tag, "_err"},   64'(bus.sel_err_o),   64'h0);
        chk({tag, "_cnt"},   64'(bus.stall_cnt_o), 64'h0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        src[0] = '0; src[1] = '0; src[2] = '0;
        drive(1'b0, 0, 3'b000, 1'b0, 1'b0);
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: basic select, back-to-back
        src[0] = 32'h11111111; src[1] = 32'h22222222; src[2] = 32'h33333333;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i, 3'b111, 1'b0, 1'b1);
            step();
        end
        chk("t1_last", 64'(bus.data_o), 64'h33333333);
        drive(1'b0, 0, 3'b111, 1'b0, 1'b1);
        step();

        // 2: load-use stall for three cycles, then accept
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1, 3'b101, 1'b0, 1'b1);
            step();
        end
        chk("t2_cnt", 64'(bus.stall_cnt_o), 64'd3);
        drive(1'b1, 1, 3'b111, 1'b0, 1'b1);
        step();
        chk("t2_data", 64'(bus.data_o), 64'h22222222);

        // 3: back-pressure holds data, no stall counting
        src[0] = 32'hDEADBEEF;
        drive(1'b1, 0, 3'b111, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1, 3'b101, 1'b0, 1'b0);
            step();
        end
        chk("t3_hold", 64'(bus.data_o), 64'hDEADBEEF);
        chk("t3_cnt",  64'(bus.stall_cnt_o), 64'd3);
        drive(1'b1, 2, 3'b111, 1'b0, 1'b1);
        step();

        // 4: out-of-range select, sticky error
        drive(1'b1, 3, 3'b000, 1'b0, 1'b1);
        step();
        chk("t4_data", 64'(bus.data_o), 64'h0);
        chk("t4_err",  64'(bus.sel_err_o), 64'h1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i, 3'b111, 1'b0, 1'b1);
            step();
        end
        chk("t4_sticky", 64'(bus.sel_err_o), 64'h1);

        // 5: flush against a held operand and a live request
        src[0] = 32'hCAFEF00D;
        drive(1'b1, 0, 3'b111, 1'b0, 1'b1);
        step();
        drive(1'b0, 0, 3'b111, 1'b0, 1'b0);
        step();
        drive(1'b1, 1, 3'b111, 1'b1, 1'b0);
        step();
        chk("t5_valid", 64'(bus.out_valid_o), 64'h0);
        chk("t5_data",  64'(bus.data_o), 64'hCAFEF00D);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            src[0] = $urandom; src[1] = $urandom; src[2] = $urandom;
            drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                  3'($urandom), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 2) != 0));
            step();
        end

        // 6: saturation, then async reset between edges
        drive(1'b0, 0, 3'b111, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 2, 3'b011, 1'b0, 1'b1);
            step();
        end
        chk("t6_sat", 64'(bus.stall_cnt_o), 64'd15);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        drive(1'b0, 0, 3'b111, 1'b0, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b1, 1, 3'b111, 1'b0, 1'b1);
        step();
        chk("post_rst_err", 64'(bus.sel_err_o), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
